// File: rtl/mem_access_pkg.sv
// Shared encodings for the data-RAM load/store front end.
// Optional perf counters: MEM_ACCESS_CTRL_PERF_EN.
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic RAM_RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU request/response and RAM pin bundle.
// slave = controller view, master = CPU/RAM side.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;
  logic              ram_rw;

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    input  ram_dout,
    output req_ready, resp_valid, resp_rdata,
    output resp_err, ram_addr, ram_din, ram_rw
  );

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    output ram_dout,
    input  req_ready, resp_valid, resp_rdata,
    input  resp_err, ram_addr, ram_din, ram_rw
  );
endinterface

// File: rtl/mem_lane_merge.sv
// Little-endian lane logic: store merge and load extension.
// Combinational only.
module mem_lane_merge
  import mem_access_pkg::*;
(
  input  logic [31:0] rd_word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        uns_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_o
);
  logic [7:0]  b;
  logic [15:0] h;

  assign b = rd_word_i[{off_i, 3'b000} +: 8];
  assign h = off_i[1] ? rd_word_i[31:16]
                      : rd_word_i[15:0];

  always_comb begin
    merged_o = rd_word_i;
    load_o   = rd_word_i;
    unique case (1'b1)
      (size_i == SIZE_BYTE): begin
        merged_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
        load_o = {{24{~uns_i & b[7]}}, b};
      end
      (size_i == SIZE_HALF): begin
        merged_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
        load_o = {{16{~uns_i & h[15]}}, h};
      end
      default: begin
        merged_o = wdata_i;
        load_o   = rd_word_i;
      end
    endcase
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store front end for the 256x32 data RAM.
// MEM_ACCESS_CTRL_PERF_EN adds perf_loads/perf_stores.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int RAM_RD_LAT = 1,
  parameter int ADDR_W     = 32,
  parameter int WORDS_LOG2 = 8
) (
  input  logic         clk,
  input  logic         rst,
  mem_access_ctrl_if.slave bus
`ifdef MEM_ACCESS_CTRL_PERF_EN
  ,
  output logic [15:0]  perf_loads,
  output logic [15:0]  perf_stores
`endif
);
  localparam int CNT_W = 8;

  state_e                state_q, state_d;
  logic                  we_q, uns_q, err_q;
  logic [1:0]            size_q, off_q;
  logic [WORDS_LOG2-1:0] widx_q;
  logic [31:0]           wdata_q, din_q, rdata_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  accept, req_err;
  logic [31:0]           merged_w, load_w;

  assign accept = bus.req_valid && (state_q == IDLE);

  assign req_err =
      (bus.req_size == 2'b11) ||
      (bus.req_size == SIZE_HALF && bus.req_addr[0]) ||
      (bus.req_size == SIZE_WORD && |bus.req_addr[1:0]) ||
      (|bus.req_addr[ADDR_W-1:WORDS_LOG2+2]);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (accept) begin
          if (req_err)
            state_d = RESP;
          else if (bus.req_we && bus.req_size == SIZE_WORD)
            state_d = WRITE;
          else
            state_d = READ;
        end
      READ:
        if (cnt_q == '0)
          state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SIZE_BYTE;
      off_q   <= 2'b00;
      widx_q  <= '0;
      wdata_q <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= bus.req_we;
        uns_q   <= bus.req_unsigned;
        err_q   <= req_err;
        size_q  <= bus.req_size;
        off_q   <= bus.req_addr[1:0];
        widx_q  <= bus.req_addr[WORDS_LOG2+1:2];
        wdata_q <= bus.req_wdata;
        din_q   <= bus.req_wdata;
        rdata_q <= '0;
        cnt_q   <= CNT_W'(RAM_RD_LAT);
      end
      // last READ cycle: ram_dout is valid now
      if (state_q == READ) begin
        if (cnt_q == '0) begin
          if (we_q) din_q   <= merged_w;
          else      rdata_q <= load_w;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

  mem_lane_merge u_merge (
    .rd_word_i (bus.ram_dout),
    .wdata_i   (wdata_q),
    .size_i    (size_q),
    .off_i     (off_q),
    .uns_i     (uns_q),
    .merged_o  (merged_w),
    .load_o    (load_w)
  );

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_err   = (state_q == RESP) && err_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.ram_addr   =
      {{(ADDR_W-WORDS_LOG2){1'b0}}, widx_q};
  assign bus.ram_din    = din_q;
  assign bus.ram_rw     =
      (state_q == WRITE) ? RAM_RW_WRITE : 1'b0;

`ifdef MEM_ACCESS_CTRL_PERF_EN
  logic [15:0] ld_q, st_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_q <= '0;
      st_q <= '0;
    end else if (state_q == RESP && !err_q) begin
      if (we_q) st_q <= st_q + 16'd1;
      else      ld_q <= ld_q + 16'd1;
    end
  end

  assign perf_loads  = ld_q;
  assign perf_stores = st_q;
`endif
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a 1-cycle RAM model.
// Build with MEM_ACCESS_CTRL_PERF_EN to also check perf counters.
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   rw_cnt = 0;
  logic [31:0] rw_addr = '0;
  int   n_ld_ok = 0;
  int   n_st_ok = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];

  mem_access_ctrl_if #(.ADDR_W(32)) bus();

`ifdef MEM_ACCESS_CTRL_PERF_EN
  logic [15:0] perf_loads, perf_stores;
`endif

  mem_access_ctrl #(
    .RAM_RD_LAT (1),
    .ADDR_W     (32),
    .WORDS_LOG2 (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef MEM_ACCESS_CTRL_PERF_EN
    ,
    .perf_loads  (perf_loads),
    .perf_stores (perf_stores)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [256];
  logic [31:0] dout_q = '0;
  initial for (int i = 0; i < 256; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (bus.ram_rw) mem[bus.ram_addr[7:0]] <= bus.ram_din;
    dout_q <= mem[bus.ram_addr[7:0]];
  end
  assign bus.ram_dout = dout_q;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.ram_rw === 1'b1) begin
      rw_cnt++;
      rw_addr = bus.ram_addr;
    end
    if (bus.resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexp_resp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rdata", bus.resp_rdata, e.rdata);
        chk("err", 32'(bus.resp_err), 32'(e.err));
        chk("lat", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  function automatic logic [31:0] ref_load(
      logic [31:0] w, logic [1:0] sz,
      logic [1:0] off, logic uns);
    logic [31:0] s;
    s = w >> (8 * off);
    if (sz == 2'b00)
      return uns ? {24'd0, s[7:0]} : {{24{s[7]}}, s[7:0]};
    if (sz == 2'b01)
      return uns ? {16'd0, s[15:0]} : {{16{s[15]}}, s[15:0]};
    return w;
  endfunction

  function automatic logic [31:0] ref_store(
      logic [31:0] w, logic [31:0] wd,
      logic [1:0] sz, logic [1:0] off);
    logic [31:0] m;
    m = (sz == 2'b00) ? 32'hFF :
        (sz == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
    m = m << (8 * off);
    return (w & ~m) | ((wd << (8 * off)) & m);
  endfunction

  task automatic send(input logic we, input logic [1:0] sz,
                      input logic uns, input logic [31:0] addr,
                      input logic [31:0] wd,
                      input logic [31:0] exp_rd,
                      input logic exp_err, input bit push,
                      output int acc);
    exp_t e;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    for (int k = 0; k < 40 && bus.req_ready !== 1'b1; k++)
      @(negedge clk);
    acc = cyc;
    if (bus.req_ready !== 1'b1) begin
      chk("accept_timeout", 32'd0, 32'd1);
      return;
    end
    if (push) begin
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.acc   = cyc;
      e.lat   = exp_err ? 1 : (we && sz == 2'b10) ? 2 : we ? 4 : 3;
      sb.push_back(e);
      if (!exp_err) begin
        if (we) n_st_ok++;
        else    n_ld_ok++;
      end
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && sb.size() != 0; k++)
      @(negedge clk);
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic op(input logic we, input logic [1:0] sz,
                    input logic uns, input logic [31:0] addr,
                    input logic [31:0] wd,
                    input logic [31:0] exp_rd,
                    input logic exp_err);
    int a;
    send(we, sz, uns, addr, wd, exp_rd, exp_err, 1'b1, a);
    idle();
    drain();
  endtask

  logic [31:0] ref_mem [8];

  initial begin
    int r0, a0, a1, a2;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rvalid", 32'(bus.resp_valid), 32'd0);
    chk("rst_err", 32'(bus.resp_err), 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_addr", bus.ram_addr, 32'd0);
    chk("rst_din", bus.ram_din, 32'd0);
    chk("rst_rw", 32'(bus.ram_rw), 32'd0);
    rst = 1'b0;

    r0 = rw_cnt;
    op(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    chk("t1_rw_pulses", 32'(rw_cnt - r0), 32'd1);
    chk("t1_rw_addr", rw_addr, 32'd4);
    op(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);

    op(1, 2'b10, 0, 32'h10, 32'h11223344, 32'h0, 0);
    r0 = rw_cnt;
    op(1, 2'b00, 0, 32'h11, 32'h123456AA, 32'h0, 0);
    chk("t2_rw_pulses", 32'(rw_cnt - r0), 32'd1);
    op(0, 2'b10, 0, 32'h10, 32'h0, 32'h1122AA44, 0);
    op(0, 2'b00, 0, 32'h11, 32'h0, 32'hFFFFFFAA, 0);
    op(0, 2'b00, 1, 32'h11, 32'h0, 32'h000000AA, 0);

    op(1, 2'b10, 0, 32'h10, 32'h80011234, 32'h0, 0);
    op(0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFF8001, 0);
    op(0, 2'b01, 1, 32'h12, 32'h0, 32'h00008001, 0);
    op(0, 2'b01, 1, 32'h10, 32'h0, 32'h00001234, 0);
    r0 = rw_cnt;
    op(1, 2'b01, 0, 32'h13, 32'h0000BEEF, 32'h0, 1);
    chk("t3_no_rw", 32'(rw_cnt - r0), 32'd0);

    op(0, 2'b10, 0, 32'h400, 32'h0, 32'h0, 1);
    op(0, 2'b11, 0, 32'h0, 32'h0, 32'h0, 1);
    op(0, 2'b10, 0, 32'h3FC, 32'h0, 32'h0, 0);

    op(1, 2'b10, 0, 32'h20, 32'h55667788, 32'h0, 0);
    r0 = rw_cnt;
    send(1, 2'b00, 0, 32'h21, 32'h99, 32'h0, 0, 1'b0, a0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_ld_ok = 0;
    n_st_ok = 0;
    chk("t5_ready", 32'(bus.req_ready), 32'd1);
    chk("t5_rw", 32'(bus.ram_rw), 32'd0);
    repeat (6) @(negedge clk);
    chk("t5_no_rw", 32'(rw_cnt - r0), 32'd0);
    op(0, 2'b10, 0, 32'h20, 32'h0, 32'h55667788, 0);

    send(1, 2'b10, 0, 32'h80, 32'hCAFEF00D, 32'h0, 0, 1'b1, a0);
    send(0, 2'b10, 0, 32'h80, 32'h0, 32'hCAFEF00D, 0, 1'b1, a1);
    send(1, 2'b00, 0, 32'h81, 32'h5A, 32'h0, 0, 1'b1, a2);
    idle();
    drain();
    chk("t6_b2b_ws", 32'(a1 - a0), 32'd3);
    chk("t6_b2b_ld", 32'(a2 - a1), 32'd4);
    op(0, 2'b10, 0, 32'h80, 32'h0, 32'hCAFE5A0D, 0);

    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    for (int i = 0; i < 24; i++) begin
      logic [2:0]  w;
      logic [1:0]  off, sz;
      logic        we, uns, err;
      logic [31:0] wd, ex;
      w   = 3'($urandom_range(0, 7));
      off = 2'($urandom_range(0, 3));
      sz  = 2'($urandom_range(0, 3));
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      wd  = $urandom;
      err = (sz == 2'b11) || (sz == 2'b01 && off[0]) ||
            (sz == 2'b10 && off != 2'b00);
      ex  = '0;
      if (!err) begin
        if (we) ref_mem[w] = ref_store(ref_mem[w], wd, sz, off);
        else    ex = ref_load(ref_mem[w], sz, off, uns);
      end
      op(we, sz, uns, 32'h40 + {27'd0, w, 2'b00} + {30'd0, off},
         wd, ex, err);
    end

`ifdef MEM_ACCESS_CTRL_PERF_EN
    chk("perf_loads", {16'd0, perf_loads}, 32'(n_ld_ok));
    chk("perf_stores", {16'd0, perf_stores}, 32'(n_st_ok));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
